// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one radix-2 step per clock.
// Multiply is shift-add on magnitudes and divide is restoring shift-subtract
// on magnitudes. The sign is fixed up on the final iteration edge.
// Divide-by-zero and signed overflow are resolved at acceptance and skip CALC.
`timescale 1ns/1ps

module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Captured request: opcode plus the precomputed sign fix-up.
  typedef struct packed {
    logic [2:0] op;
    logic       neg;
  } ctl_t;

  state_t               state_q, state_d;
  ctl_t                 ctl_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;    // mul: {hi, lo/multiplier}; div: {rem, quo/dividend}
  logic [WIDTH-1:0]     opnd_q;   // mul: multiplicand magnitude; div: divisor magnitude

  // Request decode on the live inputs, only used at the accepting edge.
  logic             a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;
  logic             div_by_zero, div_ovf, fast;

  // Decode signedness, magnitudes and the fast-path result.
  always_comb begin
    a_signed    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed    = op[2] ? ~op[0] : ~op[1];
    a_neg       = a_signed & A[WIDTH-1];
    b_neg       = b_signed & B[WIDTH-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    // The remainder follows the dividend. Everything else follows the sign XOR.
    res_neg     = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = op[2] & (B == '0);
    div_ovf     = op[2] & ~op[0] & (A == MIN_S) & (B == '1);
    fast        = div_by_zero | div_ovf;
    fast_res    = '0;
    if (div_by_zero)  fast_res = op[1] ? A : '1;
    else if (div_ovf) fast_res = op[1] ? '0 : A;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]       sum, shifted, diff;
  logic                 take;
  logic [WIDTH-1:0]     rem_n;
  logic [2*WIDTH-1:0]   acc_nxt;
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd_q};
    take    = ~diff[WIDTH];
    rem_n   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    acc_nxt = ctl_q.op[2] ? {rem_n, acc_q[WIDTH-2:0], take}
                          : {sum, acc_q[WIDTH-1:1]};
  end

  // Sign-correct and select the final result from the last step's value.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, final_res;
  always_comb begin
    prod = ctl_q.neg ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[WIDTH-1:0];
    rem  = acc_nxt[2*WIDTH-1:WIDTH];
    case (ctl_q.op)
      OP_MUL:                       final_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV:                       final_res = ctl_q.neg ? -quo : quo;
      OP_DIVU:                      final_res = quo;
      OP_REM:                       final_res = ctl_q.neg ? -rem : rem;
      OP_REMU:                      final_res = rem;
      default:                      final_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = fast ? S_DONE : S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture at acceptance, iterate in CALC, register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      result <= '0;
    end else if (state_q == S_IDLE && start) begin
      ctl_q.op  <= op;
      ctl_q.neg <= res_neg;
      cnt_q     <= '0;
      if (fast) begin
        result <= fast_res;
      end else if (op[2]) begin
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
        opnd_q <= b_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, b_mag};
        opnd_q <= a_mag;
      end
    end else if (state_q == S_CALC) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) result <= final_res;
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors against hand-computed values, plus an
// arithmetic/timing reference model compared on every cycle for WIDTH=32.
`timescale 1ns/1ps

module tb_mul_div_unit;
  localparam int W = 32;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, zero8;
  logic [7:0]  result8;

  int n_tests = 0, n_fail = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .result(result), .zero(zero));

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic for a w-bit machine.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                            input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mask, ux, uy, p;
    longint      sx, sy;
    mask = (64'd1 << w) - 64'd1;
    ux   = {32'b0, x} & mask;
    uy   = {32'b0, y} & mask;
    sx   = longint'(ux ^ (64'd1 << (w-1))) - longint'(64'd1 << (w-1));
    sy   = longint'(uy ^ (64'd1 << (w-1))) - longint'(64'd1 << (w-1));
    case (f)
      3'd0: p = 64'(sx * sy);
      3'd1: p = 64'(sx * sy) >> w;
      3'd2: p = 64'(sx * longint'(uy)) >> w;
      3'd3: p = (ux * uy) >> w;
      3'd4: p = (uy == 0) ? mask : 64'(sx / sy);
      3'd5: p = (uy == 0) ? mask : ux / uy;
      3'd6: p = (uy == 0) ? ux : 64'(sx % sy);
      default: p = (uy == 0) ? ux : ux % uy;
    endcase
    return 32'(p & mask);
  endfunction

  // Reference timing: accept only when free, done W edges later (or at once
  // for divide-by-zero / signed overflow), result held until replaced.
  logic [31:0] m_res = '0, m_pend = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_pend <= '0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_pend <= ref_model(W, op, a, b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) begin
          m_done <= 1'b1;
          m_res  <= ref_model(W, op, a, b);
        end else begin
          m_cnt <= W;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end
  end

  // Compare the 32-bit DUT against the model every cycle.
  always @(negedge clk) begin
    check("busy",   {31'b0, busy}, {31'b0, m_busy});
    check("done",   {31'b0, done}, {31'b0, m_done});
    check("result", result, m_res);
    check("zero",   {31'b0, zero}, {31'b0, (m_res == 0)});
  end

  task automatic run(input string nm, input logic [2:0] f, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    check({nm, "_model"}, ref_model(W, f, x, y), exp);
    @(posedge clk); #2;
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; op = ~f; a = $urandom; b = $urandom;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!done && n < 200);
    check({nm, "_lat"}, 32'(n), 32'(lat));
    check({nm, "_res"}, result, exp);
    check({nm, "_zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
  endtask

  task automatic run8(input string nm, input logic [2:0] f, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] exp, input int lat);
    int n;
    check({nm, "_model"}, ref_model(8, f, {24'b0, x}, {24'b0, y}), {24'b0, exp});
    @(posedge clk); #2;
    start8 = 1'b1; op8 = f; a8 = x; b8 = y;
    @(posedge clk); #2;
    start8 = 1'b0; op8 = ~f; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!done8 && n < 200);
    check({nm, "_lat"}, 32'(n), 32'(lat));
    check({nm, "_res"}, {24'b0, result8}, {24'b0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_done",   {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_zero",   {31'b0, zero}, 32'd1);
    @(posedge clk); #2; rst_n = 1'b1;

    // Multiply.
    run("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulh",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         33);
    run("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("mulhu2",  3'b011, 32'h8000_0000,  32'd4,         32'd2,         33);
    // Divide.
    run("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run("div_nn",  3'b100, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         33);
    run("rem_nn",  3'b110, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    run("divu",    3'b101, 32'd100,        32'd7,         32'd14,        33);
    run("remu",    3'b111, 32'd100,        32'd7,         32'd2,         33);
    run("divu_big",3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
    // Fast path.
    run("divu_z",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("rem_z",   3'b110, 32'd5,          32'd0,         32'd5,         1);
    run("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    run("mul_nz",  3'b000, 32'd6,          32'd7,         32'd42,        33);

    // Reset in the middle of CALC: immediate abort, no done pulse.
    @(posedge clk); #2;
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(posedge clk); #2; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'b0, busy}, 32'd0);
    check("midrst_done",   {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_zero",   {31'b0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_nodone", 32'(seen), 32'd0);

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      start = 1'b1;
      op    = 3'($urandom_range(0, 7));
      a     = $urandom;
      b     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    end
    @(posedge clk); #2; start = 1'b0;
    repeat (40) @(posedge clk);

    // WIDTH=8 build.
    run8("w8_mul", 3'b000, 8'h7F, 8'h02, 8'hFE, 9);
    run8("w8_div", 3'b100, 8'h80, 8'hFF, 8'h80, 1);
    run8("w8_rem", 3'b110, 8'hF9, 8'h02, 8'hFF, 9);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit: the RV32M companion to the single-cycle combinational ALU.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over WIDTH-bit operands, one radix-2 step per clock.
- Uses a start/busy/done handshake so the core stalls its execute stage while the unit is busy.
- Exposes a zero flag with the same meaning as the ALU's.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  WIDTH  rs1 operand (multiplicand / dividend); sampled with start.
- B  input  WIDTH  rs2 operand (multiplier / divisor); sampled with start.
- busy  output  1  unit occupied (CALC or DONE).
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  registered result; held until the next accepted start.
- zero  output  1  (result == 0), combinational from result.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, result=0, counter=0, internal registers 0; zero=1.
- Reset mid-operation aborts immediately; no done pulse is produced.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge captures A, B and op.
  - Normal path: go to CALC with counter=0, busy=1.
  - Fast path: go directly to DONE.
- Fast path (divide ops only):
  - B==0: DIV/DIVU result = all ones; REM/REMU result = A.
  - DIV/REM with A = -2^(WIDTH-1) and B = -1: DIV result = A; REM result = 0.
  - Result is registered at the accepting edge; done is high in the following cycle.
- CALC:
  - One iteration per edge; counter increments.
  - After the WIDTH-th iteration edge, the final sign-corrected result is registered, state becomes DONE and done=1.
  - Normal-path latency: done asserts in the cycle after edge t0+WIDTH, where t0 is the accepting edge. That is WIDTH+1 cycles from start to done.
- DONE: lasts exactly one cycle (done=1, busy=1), then returns to IDLE (busy=0, done=0).
- start while busy: ignored, with no queuing. Operands presented then are not captured.
- Multiply:
  - Operands converted to magnitudes per signedness: MUL/MULH both signed, MULHSU A signed B unsigned, MULHU both unsigned.
  - Shift-add into a 2*WIDTH accumulator.
  - Product negated if the operand signs differ (signed operands only).
  - MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - Quotient negated if signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - Results truncate toward zero.
- Arithmetic is modulo 2^WIDTH; no exceptions or flags other than zero.
- op is captured with start; changes to A, B or op after acceptance have no effect.

Test Plan:
- Reset, WIDTH=32: rst_n low -> busy=0, done=0, result=0x00000000, zero=1. Assert rst_n low again during CALC -> immediate return to that state, no done pulse.
- Multiply, WIDTH=32:
  - MUL A=7, B=-3 -> done at cycle 33 after start, result=0xFFFFFFEB.
  - MULHU A=B=0xFFFFFFFF -> result=0xFFFFFFFE.
  - MULH same operands -> result=0x00000000, zero=1.
  - MULHSU A=-1, B=0xFFFFFFFF -> result=0xFFFFFFFF.
- Divide, WIDTH=32:
  - DIV A=-7, B=2 -> result=0xFFFFFFFD (-3).
  - REM same operands -> result=0xFFFFFFFF (-1).
  - DIVU A=100, B=7 -> result=14.
  - REMU same operands -> result=2.
- Fast path, WIDTH=32, done one cycle after start:
  - DIVU A=5, B=0 -> result=0xFFFFFFFF.
  - REM A=5, B=0 -> result=5.
  - DIV A=0x80000000, B=-1 -> result=0x80000000.
  - REM same operands -> result=0, zero=1.
- Handshake: start held high continuously with changing operands -> only the operand set present at each IDLE edge is accepted. done pulses exactly one cycle, and result stays stable until the next acceptance.
- WIDTH=8 build: MUL A=0x7F, B=0x02 -> result=0xFE, latency 9 cycles. DIV A=0x80, B=0xFF -> result=0x80.
